// File: rtl/fifo_ptr_status.sv
// Per-domain pointer and status engine for an asynchronous FIFO.
// SIDE=0 runs in the read domain (empty / almost_empty, pop requests).
// SIDE=1 runs in the write domain (full / almost_full, push requests).
// The remote Gray pointer is assumed to be synchronised into this domain
// already; every status output is registered, so nothing from rgray_i
// reaches an output combinationally.
module fifo_ptr_status #(
  parameter int SIDE       = 0,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH:0]   rgray_i,
  input  logic [ADDR_WIDTH:0]   thresh_i,
  input  logic                  clr_err_i,
  output logic                  accept_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH:0]   lgray_o,
  output logic                  flag_o,
  output logic                  almost_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic                  ptr_err_o
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]        DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PW-1:0]        bin_q, bin_d;
  logic [PW-1:0]        gray_q, gray_d;
  logic [PW-1:0]        level_q, lvl_d;
  logic [PW-1:0]        rbin;
  logic                 flag_q, flag_d;
  logic                 almost_q, almost_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 ptr_err_q, ptr_err_d;
  logic                 viol;

  // A request is taken only when the registered primary flag allows it and
  // the block is not held in reset (the write side's reset flag is 0).
  assign accept_o = req_i & ~flag_q & ~rst;
  assign viol     = req_i & flag_q;

  // Gray-to-binary of the remote pointer: each bit is the XOR of itself and
  // all more-significant Gray bits.
  always_comb begin
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(rgray_i >> i);
    end
  end

  // Next pointer, fill level, flags and error status. Local accept and a
  // remote pointer move fold into one exact subtraction, so no priority.
  always_comb begin
    // NOTE: every combinational output gets a default up front so no path
    // through the if/else chains below can leave it unassigned (no latch).
    bin_d     = bin_q + PW'(accept_o);
    gray_d    = bin_d ^ (bin_d >> 1);
    lvl_d     = (SIDE == 0) ? (rbin - bin_d) : (bin_d - rbin);
    flag_d    = (SIDE == 0) ? (lvl_d == '0) : (lvl_d == DEPTH_P);
    almost_d  = (SIDE == 0) ? (lvl_d <= thresh_i) : (lvl_d >= thresh_i);
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    ptr_err_d = ptr_err_q;

    // A violation in the same cycle as a clear restarts the count at one.
    if (viol && clr_err_i) begin
      err_d     = 1'b1;
      err_cnt_d = CNT_WIDTH'(1);
    end else if (viol) begin
      err_d = 1'b1;
      if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end else if (clr_err_i) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end

    // A level beyond DEPTH can only come from a bad remote pointer.
    if (lvl_d > DEPTH_P)  ptr_err_d = 1'b1;
    else if (clr_err_i)   ptr_err_d = 1'b0;
  end

  // State registers; reset leaves the read side empty and the write side
  // not full.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state here is a small register set, so every flop is reset;
    // sequential updates use non-blocking assignments only.
    if (rst) begin
      bin_q     <= '0;
      gray_q    <= '0;
      level_q   <= '0;
      flag_q    <= (SIDE == 0);
      almost_q  <= (SIDE == 0);
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      ptr_err_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      level_q   <= lvl_d;
      flag_q    <= flag_d;
      almost_q  <= almost_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      ptr_err_q <= ptr_err_d;
    end
  end

  assign addr_o    = bin_q[ADDR_WIDTH-1:0];
  assign lgray_o   = gray_q;
  assign flag_o    = flag_q;
  assign almost_o  = almost_q;
  assign level_o   = level_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
  assign ptr_err_o = ptr_err_q;

endmodule

// File: tb/tb_fifo_ptr_status.sv
// Bench for fifo_ptr_status: one read-side and one write-side instance
// (ADDR_WIDTH=3) compared every cycle against an integer pointer model.
module tb_fifo_ptr_status;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Inputs, index 0 = read side, 1 = write side
  logic       rq  [2];
  logic       clr [2];
  logic [3:0] thr [2];
  logic [3:0] rg  [2];
  int         rem [2];

  // Outputs
  logic       acc  [2];
  logic       flg  [2];
  logic       alm  [2];
  logic       er   [2];
  logic       perr [2];
  logic [2:0] addr [2];
  logic [3:0] lg   [2];
  logic [3:0] lvl  [2];
  logic [7:0] cnt  [2];

  int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  assign rg[0] = 4'(gray_tab[rem[0]]);
  assign rg[1] = 4'(gray_tab[rem[1]]);

  fifo_ptr_status #(.SIDE(0), .ADDR_WIDTH(3), .CNT_WIDTH(8)) u_rd (
    .clk(clk), .rst(rst), .req_i(rq[0]), .rgray_i(rg[0]), .thresh_i(thr[0]),
    .clr_err_i(clr[0]), .accept_o(acc[0]), .addr_o(addr[0]), .lgray_o(lg[0]),
    .flag_o(flg[0]), .almost_o(alm[0]), .level_o(lvl[0]), .err_o(er[0]),
    .err_cnt_o(cnt[0]), .ptr_err_o(perr[0])
  );

  fifo_ptr_status #(.SIDE(1), .ADDR_WIDTH(3), .CNT_WIDTH(8)) u_wr (
    .clk(clk), .rst(rst), .req_i(rq[1]), .rgray_i(rg[1]), .thresh_i(thr[1]),
    .clr_err_i(clr[1]), .accept_o(acc[1]), .addr_o(addr[1]), .lgray_o(lg[1]),
    .flag_o(flg[1]), .almost_o(alm[1]), .level_o(lvl[1]), .err_o(er[1]),
    .err_cnt_o(cnt[1]), .ptr_err_o(perr[1])
  );

  // Reference model: local pointer as an integer 0..15, level from modular
  // distance to the remote pointer.
  typedef struct {
    int loc;
    int level;
    int cnt;
    bit flag;
    bit almost;
    bit err;
    bit ptr_err;
  } model_t;

  model_t mdl [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic model_t reset_model(input int s);
    model_t m;
    m.loc = 0; m.level = 0; m.cnt = 0;
    m.flag = (s == 0); m.almost = (s == 0);
    m.err = 0; m.ptr_err = 0;
    return m;
  endfunction

  function automatic model_t next_model(input model_t m, input int s, input bit req,
                                        input int r, input int t, input bit c);
    model_t n = m;
    bit take = req && !m.flag;
    bit bad  = req && m.flag;
    n.loc    = (m.loc + int'(take)) % 16;
    n.level  = (s == 0) ? (r - n.loc + 16) % 16 : (n.loc - r + 16) % 16;
    n.flag   = (s == 0) ? (n.level == 0) : (n.level == 8);
    n.almost = (s == 0) ? (n.level <= t) : (n.level >= t);
    if (n.level > 8) n.ptr_err = 1;
    else if (c)      n.ptr_err = 0;
    if (bad && c)  begin n.err = 1; n.cnt = 1; end
    else if (bad)  begin n.err = 1; n.cnt = (m.cnt == 255) ? 255 : m.cnt + 1; end
    else if (c)    begin n.err = 0; n.cnt = 0; end
    return n;
  endfunction

  task automatic check_all();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("s%0d_addr", s),    addr[s], mdl[s].loc % 8);
      check($sformatf("s%0d_lgray", s),   lg[s],   gray_tab[mdl[s].loc]);
      check($sformatf("s%0d_flag", s),    flg[s],  mdl[s].flag);
      check($sformatf("s%0d_almost", s),  alm[s],  mdl[s].almost);
      check($sformatf("s%0d_level", s),   lvl[s],  mdl[s].level);
      check($sformatf("s%0d_err", s),     er[s],   mdl[s].err);
      check($sformatf("s%0d_err_cnt", s), cnt[s],  mdl[s].cnt);
      check($sformatf("s%0d_ptr_err", s), perr[s], mdl[s].ptr_err);
    end
  endtask

  // Inputs are already set (at a negedge); check accept, advance the model,
  // cross one rising edge and compare everything on the next falling edge.
  task automatic step();
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("s%0d_accept", s), acc[s], rq[s] & ~mdl[s].flag);
      mdl[s] = next_model(mdl[s], s, rq[s], rem[s], int'(thr[s]), clr[s]);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit         exp_acc;
    logic [3:0] exp_lgray;
    bit         exp_almost;
    bit         exp_flag;
    int         exp_level;
    int         exp_cnt;
  } vec_t;

  vec_t fill_tab [10];

  initial begin
    fill_tab[0] = '{1'b1, 4'h1, 1'b0, 1'b0, 1, 0};
    fill_tab[1] = '{1'b1, 4'h3, 1'b0, 1'b0, 2, 0};
    fill_tab[2] = '{1'b1, 4'h2, 1'b0, 1'b0, 3, 0};
    fill_tab[3] = '{1'b1, 4'h6, 1'b0, 1'b0, 4, 0};
    fill_tab[4] = '{1'b1, 4'h7, 1'b0, 1'b0, 5, 0};
    fill_tab[5] = '{1'b1, 4'h5, 1'b1, 1'b0, 6, 0};
    fill_tab[6] = '{1'b1, 4'h4, 1'b1, 1'b0, 7, 0};
    fill_tab[7] = '{1'b1, 4'hC, 1'b1, 1'b1, 8, 0};
    fill_tab[8] = '{1'b0, 4'hC, 1'b1, 1'b1, 8, 1};
    fill_tab[9] = '{1'b0, 4'hC, 1'b1, 1'b1, 8, 2};

    for (int s = 0; s < 2; s++) begin
      rq[s] = 0; clr[s] = 0; rem[s] = 0;
      mdl[s] = reset_model(s);
    end
    thr[0] = 4'd2;
    thr[1] = 4'd6;

    // Reset state, including a write request that must be refused in reset
    rq[1] = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_wr_accept", acc[1], 0);
    check_all();
    rq[1] = 0;
    rst = 0;

    // Read side empty: three pops rejected
    rq[0] = 1;
    repeat (3) step();
    rq[0] = 0;
    check("rd_err_cnt3", cnt[0], 3);
    check("rd_err", er[0], 1);
    check("rd_addr_stuck", addr[0], 0);

    // Write side fill to full and two rejected pushes
    for (int i = 0; i < 10; i++) begin
      rq[1] = 1;
      #1;
      check($sformatf("fill%0d_accept", i), acc[1], fill_tab[i].exp_acc);
      step();
      check($sformatf("fill%0d_lgray", i),  lg[1],  fill_tab[i].exp_lgray);
      check($sformatf("fill%0d_almost", i), alm[1], fill_tab[i].exp_almost);
      check($sformatf("fill%0d_flag", i),   flg[1], fill_tab[i].exp_flag);
      check($sformatf("fill%0d_level", i),  lvl[1], fill_tab[i].exp_level);
      check($sformatf("fill%0d_err_cnt", i), cnt[1], fill_tab[i].exp_cnt);
    end
    rq[1] = 0;

    // Read-side wrap: remote pushes and local pops alternate 20 times
    clr[0] = 1; step(); clr[0] = 0;
    for (int i = 0; i < 20; i++) begin
      rem[0] = (rem[0] + 1) % 16;
      step();
      check("wrap_level_push", lvl[0], 1);
      check("wrap_flag_push", flg[0], 0);
      rq[0] = 1;
      step();
      rq[0] = 0;
      check("wrap_level_pop", lvl[0], 0);
      check("wrap_flag_pop", flg[0], 1);
      check("wrap_ptr_err", perr[0], 0);
    end
    check("wrap_addr", addr[0], 4);
    check("wrap_lgray", lg[0], 4'h6);

    // Simultaneous push and remote pop on the write side
    rem[1] = 1; step();
    check("simul_pre_level", lvl[1], 7);
    rq[1] = 1; rem[1] = 2; step();
    check("simul_level", lvl[1], 7);
    check("simul_flag", flg[1], 0);
    step();
    check("push_full_level", lvl[1], 8);
    check("push_full_flag", flg[1], 1);

    // clr_err colliding with a violation
    repeat (3) step();
    check("coll_cnt5", cnt[1], 5);
    clr[1] = 1; step();
    check("coll_err", er[1], 1);
    check("coll_cnt", cnt[1], 1);
    rq[1] = 0; step();
    clr[1] = 0;
    check("clr_err", er[1], 0);
    check("clr_cnt", cnt[1], 0);

    // Counter saturation
    rq[1] = 1;
    repeat (260) step();
    check("sat_cnt", cnt[1], 255);
    rq[1] = 0; clr[1] = 1; step(); clr[1] = 0;

    // Randomised traffic with legal remote pointer movement
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) begin
        thr[0] = 4'($urandom_range(0, 8));
        thr[1] = 4'($urandom_range(0, 8));
      end
      rq[0]  = 1'($urandom_range(0, 1));
      rq[1]  = 1'($urandom_range(0, 1));
      clr[0] = ($urandom_range(0, 15) == 0);
      clr[1] = ($urandom_range(0, 15) == 0);
      if (mdl[0].level < 8 && $urandom_range(0, 1) == 1) rem[0] = (rem[0] + 1) % 16;
      if (mdl[1].level > 0 && $urandom_range(0, 1) == 1) rem[1] = (rem[1] + 1) % 16;
      step();
    end

    // Reset asserted mid-burst clears everything without waiting for a clock
    for (int s = 0; s < 2; s++) begin rq[s] = 1; clr[s] = 0; end
    thr[0] = 4'd2;
    thr[1] = 4'd6;
    step();
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("rst_async_rd_accept", acc[0], 0);
    check("rst_async_wr_accept", acc[1], 0);
    for (int s = 0; s < 2; s++) mdl[s] = reset_model(s);
    check_all();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin rq[s] = 0; rem[s] = 0; end
    rst = 0;
    step();

    // Corrupt remote pointer on the write side
    rem[1] = 3; step();
    check("corrupt_ptr_err", perr[1], 1);
    check("corrupt_level", lvl[1], 13);
    rem[1] = 0; step();
    check("corrupt_sticky", perr[1], 1);
    clr[1] = 1; step(); clr[1] = 0;
    check("corrupt_cleared", perr[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
